readback_scheduler: RTL and testbench
=====================================

Name: readback_scheduler

Overview:
Shares the single core->Jetson SPI write path between NCH readback channels (Status, Sonar, Motor, ADC, Radio, RemoteCtl).
- Each channel gets a 1-deep holding slot.
- A round-robin pointer issues pending slots to the SPI write FIFO one word per cycle, throttled by FIFO not-full.
- Drives rd_stb / rd_addr / rd_data of the top level.
- Replaces the fixed-priority pulse arbiter; adds fairness, backpressure and overflow accounting.

Parameters:
NCH, 6, number of requesting channels (1..7).
DW, 28, readback word width: ctrl[27:24] + data[23:0].
SEL_W, 3, width of channel index on the output.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous reset, active-high.
in_req  in  NCH  per-channel one-cycle write pulse.
in_data  in  NCH*DW  packed channel words; channel i at [i*DW +: DW].
in_busy  out  NCH  slot i full; channel may use ~in_busy[i] as write-ready.
out_rdy  in  1  SPI write FIFO not full.
out_stb  out  1  one-cycle FIFO write strobe.
out_data  out  DW  word being written.
out_sel  out  SEL_W  channel index of out_data (becomes rd_addr[2:0]).
ovf  out  NCH  sticky per-channel overflow flags.
ovf_clr  in  1  clears all ovf flags.

Behaviour:
- Reset values: out_stb=0, out_data=0, out_sel=0, in_busy=0, ovf=0, rr pointer=0; all slots empty.
- Slot load: in_req[i] with slot i empty -> word latched, slot full from next cycle (in_busy[i]=1).
- Slot overwrite: in_req[i] with slot i full and not being granted this cycle -> newest word replaces slot; ovf[i] set.
- Grant: every cycle with out_rdy=1 and any slot full -> pick first full slot at or after rr pointer (wrapping NCH-1 -> 0).
  - Next cycle: out_stb=1, out_data = slot word, out_sel = index.
  - Granted slot emptied; rr pointer = granted index + 1 (mod NCH).
- out_rdy=0: no grant; out_stb=0 next cycle; slots hold (still subject to overwrite).
- Simultaneous grant and in_req on the same slot: granted word is issued; new word loads; slot stays full; no overflow.
- Latency: in_req at cycle t -> earliest out_stb at t+2.
- Throughput: one word per cycle while out_rdy=1.
- ovf_clr and overflow on the same cycle: set wins.
- Mid-operation reset: slots discarded, no strobe issued; any in-flight out_stb deasserts asynchronously.
- States:
  - IDLE: no slot full.
  - ARB: ≥1 full, out_rdy=1.
  - STALL: ≥1 full, out_rdy=0.
  - Transitions depend only on slot occupancy and out_rdy. Outputs are registered and valid in every state.

Optional Feature:
READBACK_SCHED_OVF_REPORT_EN
- Defined:
  - A rising ovf[i] queues a report word: out_sel=7, ctrl=4'hF, data[NCH-1:0]=ovf snapshot, rest 0.
  - The report has a dedicated slot that wins over the rr pick.
  - The report slot is never overwritten; at most one is pending, re-armed after issue.
- Undefined:
  - Overflow is visible only via the ovf port.
  - out_sel never equals 7.

Decomposition:
- Package readback_pkg:
  - RB_DW=28, RB_CTRL_W=4, RB_SEL_W=3
  - RB_OVF_SEL=3'd7, RB_OVF_CTRL=4'hF
  - typedef rb_word_t {ctrl[3:0], data[23:0]}
- Sub-module rr_pick: combinational round-robin first-set finder (req vector, pointer -> found, index). Reusable by other arbiters.

Test Plan:
- Single req on ch2, data 0x1ABCDEF, out_rdy=1 -> out_stb at t+2, out_sel=2, out_data=0x1ABCDEF; in_busy[2] high exactly 1 cycle.
- Reqs on ch0, ch3, ch5 in the same cycle, pointer=0 -> strobes on 3 consecutive cycles, out_sel order 0, 3, 5; pointer ends at 0.
- out_rdy=0; ch1 req 0xA then 0xB -> ovf[1]=1, no strobes; out_rdy=1 -> single strobe with 0xB; ovf_clr -> ovf=0.
- Continuous req on all 6 channels, out_rdy=1 -> each channel issued once per 6 strobes, no channel starved, no ovf.
- Reset asserted while slots 1 and 4 full -> outputs zero immediately; after release, no strobe until a new req.
- With READBACK_SCHED_OVF_REPORT_EN: overflow on ch4 -> next strobe out_sel=7, out_data=0xF000010; then normal rr resumes.

Source files
------------

// File: rtl/readback_pkg.sv
// Shared types and constants for the core->Jetson readback path.
// Word layout: ctrl[27:24] + data[23:0]; channel index travels separately as a 3-bit select.
package readback_pkg;

    localparam int RB_DW     = 28;
    localparam int RB_CTRL_W = 4;
    localparam int RB_DATA_W = 24;
    localparam int RB_SEL_W  = 3;

    localparam logic [RB_SEL_W-1:0]  RB_OVF_SEL  = 3'd7;
    localparam logic [RB_CTRL_W-1:0] RB_OVF_CTRL = 4'hF;

    typedef struct packed {
        logic [RB_CTRL_W-1:0] ctrl;
        logic [RB_DATA_W-1:0] data;
    } rb_word_t;

    // Scheduler phase: nothing pending / issuing / held off by a full FIFO.
    typedef enum logic [1:0] {
        RB_IDLE  = 2'd0,
        RB_ARB   = 2'd1,
        RB_STALL = 2'd2
    } rb_state_t;

    // Builds the overflow report word from a snapshot of the sticky flags.
    function automatic rb_word_t rb_ovf_report(input logic [RB_DATA_W-1:0] snap);
        rb_word_t w;
        w.ctrl = RB_OVF_CTRL;
        w.data = snap;
        return w;
    endfunction

endpackage

// File: rtl/readback_scheduler_rr_pick.sv
// Combinational round-robin first-set finder: returns the first set request
// at or after ptr, wrapping from N-1 back to 0. Usable by any arbiter.
module rr_pick #(
    parameter int N  = 6,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [N-1:0] hi_s;
    logic [N-1:0] scan_s;

    // Keep only requests at or above the pointer (the non-wrapped part of the scan).
    always_comb begin
        hi_s = '0;
        for (int k = 0; k < N; k++) begin
            hi_s[k] = req[k] & (IW'(k) >= ptr);
        end
    end

    // Lowest set bit of the upper part wins; otherwise wrap to the lowest set bit overall.
    always_comb begin
        scan_s = (|hi_s) ? hi_s : req;
        found  = |req;
        idx    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = scan_s[k] ? IW'(k) : idx;
        end
    end

endmodule

// File: rtl/readback_scheduler.sv
// Readback scheduler: per-channel 1-deep slots feeding the single SPI write
// FIFO through a round-robin pointer, with sticky per-channel overflow flags.
// Optional build macro READBACK_SCHED_OVF_REPORT_EN: a rising overflow flag
// queues a report word (sel 7, ctrl 4'hF, data = flag snapshot) that takes
// precedence over the round-robin pick.
module readback_scheduler
    import readback_pkg::*;
#(
    parameter int NCH   = 6,
    parameter int DW    = RB_DW,
    parameter int SEL_W = RB_SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   in_req,
    input  logic [NCH*DW-1:0] in_data,
    output logic [NCH-1:0]   in_busy,
    input  logic             out_rdy,
    output logic             out_stb,
    output logic [DW-1:0]    out_data,
    output logic [SEL_W-1:0] out_sel,
    output logic [NCH-1:0]   ovf,
    input  logic             ovf_clr
);

    logic [NCH-1:0]   slot_full_r;
    logic [DW-1:0]    slot_word_r [NCH];
    logic [SEL_W-1:0] rr_ptr_r;
    rb_state_t        state_r;
    rb_state_t        state_nxt_s;

    logic             pick_found_s;
    logic [SEL_W-1:0] pick_idx_s;
    logic [SEL_W-1:0] ptr_nxt_s;
    logic             pending_s;
    logic             grant_s;
    logic [NCH-1:0]   gnt_vec_s;
    logic [NCH-1:0]   ovf_set_s;
    logic [NCH-1:0]   ovf_nxt_s;

`ifdef READBACK_SCHED_OVF_REPORT_EN
    logic             rep_pend_r;
    logic [DW-1:0]    rep_word_r;
    logic             rep_grant_s;
    logic [NCH-1:0]   ovf_rise_s;
`endif

    assign in_busy = slot_full_r;

    rr_pick #(.N(NCH), .IW(SEL_W)) u_pick (
        .req   (slot_full_r),
        .ptr   (rr_ptr_r),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Anything waiting to be issued (channel slots plus the report slot when built in).
    always_comb begin
`ifdef READBACK_SCHED_OVF_REPORT_EN
        pending_s = (|slot_full_r) | rep_pend_r;
`else
        pending_s = |slot_full_r;
`endif
    end

    // Phase register: remembers the phase of the cycle just closed, so ARB here means a word is on the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RB_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Phase of the current cycle, from slot occupancy and FIFO space only.
    always_comb begin
        state_nxt_s = RB_IDLE;
        if (!pending_s) begin
            state_nxt_s = RB_IDLE;
        end else if (out_rdy) begin
            state_nxt_s = RB_ARB;
        end else begin
            state_nxt_s = RB_STALL;
        end
    end

    // Strobe decodes the registered phase; grant decisions decode the current phase.
    always_comb begin
        out_stb = (state_r == RB_ARB);
        grant_s = 1'b0;
`ifdef READBACK_SCHED_OVF_REPORT_EN
        rep_grant_s = 1'b0;
`endif
        case (state_nxt_s)
            RB_ARB: begin
`ifdef READBACK_SCHED_OVF_REPORT_EN
                rep_grant_s = rep_pend_r;
                grant_s     = pick_found_s & ~rep_pend_r;
`else
                grant_s     = pick_found_s;
`endif
            end
            default: begin
                grant_s = 1'b0;
            end
        endcase
    end

    // Per-slot grant decode, overflow detection (set beats clear) and pointer advance.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            gnt_vec_s[i] = grant_s & (pick_idx_s == SEL_W'(i));
        end
        ovf_set_s = in_req & slot_full_r & ~gnt_vec_s;
        ovf_nxt_s = ovf_set_s | (ovf & {NCH{~ovf_clr}});
        ptr_nxt_s = (pick_idx_s == SEL_W'(NCH - 1)) ? '0 : pick_idx_s + SEL_W'(1);
    end

    // Slot loads, grant bookkeeping and the registered output word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_full_r <= '0;
            for (int i = 0; i < NCH; i++) begin
                slot_word_r[i] <= '0;
            end
            rr_ptr_r <= '0;
            ovf      <= '0;
            out_data <= '0;
            out_sel  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (in_req[i]) begin
                    slot_word_r[i] <= in_data[i*DW +: DW];
                end
            end
            slot_full_r <= (slot_full_r & ~gnt_vec_s) | in_req;
            ovf         <= ovf_nxt_s;
            if (grant_s) begin
                out_data <= slot_word_r[pick_idx_s];
                out_sel  <= pick_idx_s;
                rr_ptr_r <= ptr_nxt_s;
            end
`ifdef READBACK_SCHED_OVF_REPORT_EN
            else if (rep_grant_s) begin
                out_data <= rep_word_r;
                out_sel  <= SEL_W'(RB_OVF_SEL);
            end
`endif
        end
    end

`ifdef READBACK_SCHED_OVF_REPORT_EN
    // Flags going 0->1 this cycle trigger a report.
    always_comb begin
        ovf_rise_s = ovf_nxt_s & ~ovf;
    end

    // Report slot: never overwritten while pending, re-armed in the cycle it issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_pend_r <= 1'b0;
            rep_word_r <= '0;
        end else if ((|ovf_rise_s) && (!rep_pend_r || rep_grant_s)) begin
            rep_pend_r <= 1'b1;
            rep_word_r <= DW'(rb_ovf_report(RB_DATA_W'(ovf_nxt_s)));
        end else if (rep_grant_s) begin
            rep_pend_r <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_readback_scheduler.sv
// Self-checking bench for readback_scheduler: a cycle model predicts each
// issued word into a queue; words are popped and compared as the DUT strobes.
`timescale 1ns/1ps
module tb_readback_scheduler;

    localparam int NCH   = 6;
    localparam int DW    = 28;
    localparam int SEL_W = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    in_req;
    logic [NCH*DW-1:0] in_data;
    logic [NCH-1:0]    in_busy;
    logic              out_rdy;
    logic              out_stb;
    logic [DW-1:0]     out_data;
    logic [SEL_W-1:0]  out_sel;
    logic [NCH-1:0]    ovf;
    logic              ovf_clr;

    readback_scheduler #(.NCH(NCH), .DW(DW), .SEL_W(SEL_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_req   (in_req),
        .in_data  (in_data),
        .in_busy  (in_busy),
        .out_rdy  (out_rdy),
        .out_stb  (out_stb),
        .out_data (out_data),
        .out_sel  (out_sel),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SEL_W-1:0] sel;
        logic [DW-1:0]    data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] sel_log[$];
    logic [31:0] data_log[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_stb = 0;
    int          tally [NCH];

    // reference model state
    logic [NCH-1:0] m_full;
    logic [DW-1:0]  m_word [NCH];
    int             m_ptr;
    logic [NCH-1:0] m_ovf;
    logic           m_stb;
    logic           m_rep_pend;
    logic [DW-1:0]  m_rep_word;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full     = '0;
        for (int i = 0; i < NCH; i++) m_word[i] = '0;
        m_ptr      = 0;
        m_ovf      = '0;
        m_stb      = 1'b0;
        m_rep_pend = 1'b0;
        m_rep_word = '0;
        exp_q.delete();
    endtask

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic model_step();
        logic [NCH-1:0] gvec;
        logic [NCH-1:0] oset;
        logic [NCH-1:0] onew;
        logic           rep_issue;
        int             g;
        int             j;
        gvec      = '0;
        rep_issue = 1'b0;
        m_stb     = 1'b0;
        g         = -1;
        if (out_rdy) begin
            if (m_rep_pend) begin
                rep_issue = 1'b1;
                m_stb     = 1'b1;
                exp_q.push_back('{sel: 3'd7, data: m_rep_word});
            end else begin
                for (int k = 0; k < NCH; k++) begin
                    j = (m_ptr + k) % NCH;
                    if (g < 0 && m_full[j]) g = j;
                end
                if (g >= 0) begin
                    gvec[g] = 1'b1;
                    m_stb   = 1'b1;
                    exp_q.push_back('{sel: SEL_W'(g), data: m_word[g]});
                    m_ptr   = (g + 1) % NCH;
                end
            end
        end
        oset = in_req & m_full & ~gvec;
        onew = oset | (ovf_clr ? '0 : m_ovf);
`ifdef READBACK_SCHED_OVF_REPORT_EN
        if (((onew & ~m_ovf) != '0) && (!m_rep_pend || rep_issue)) begin
            m_rep_pend = 1'b1;
            m_rep_word = {4'hF, 24'(onew)};
        end else if (rep_issue) begin
            m_rep_pend = 1'b0;
        end
`endif
        for (int i = 0; i < NCH; i++) begin
            if (in_req[i]) m_word[i] = in_data[i*DW +: DW];
        end
        m_full = (m_full & ~gvec) | in_req;
        m_ovf  = onew;
    endtask

    // One clock: predict, clock, then compare 1 ns after the edge.
    task automatic cycle();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        check_eq("stb", {31'd0, out_stb}, {31'd0, m_stb});
        if (out_stb === 1'b1) begin
            n_stb++;
            sel_log.push_back(32'(out_sel));
            data_log.push_back(32'(out_data));
            if (int'(out_sel) < NCH) tally[int'(out_sel)]++;
            check_eq("q_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("sel", 32'(out_sel), 32'(e.sel));
                check_eq("data", 32'(out_data), 32'(e.data));
            end
        end
        check_eq("busy", 32'(in_busy), 32'(m_full));
        check_eq("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    task automatic set_word(input int ch, input logic [DW-1:0] w);
        in_data[ch*DW +: DW] = w;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int s0;
        int cyc;
        rst     = 1'b1;
        in_req  = '0;
        in_data = '0;
        out_rdy = 1'b0;
        ovf_clr = 1'b0;
        for (int i = 0; i < NCH; i++) tally[i] = 0;
        apply_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_stb", {31'd0, out_stb}, 32'd0);
        check_eq("rst_data", 32'(out_data), 32'd0);
        check_eq("rst_sel", 32'(out_sel), 32'd0);
        check_eq("rst_busy", 32'(in_busy), 32'd0);
        check_eq("rst_ovf", 32'(ovf), 32'd0);
        apply_reset();

        // single request on ch2: strobe two clocks after the request
        out_rdy = 1'b1;
        in_req  = 6'b000100;
        set_word(2, 28'h1ABCDEF);
        cycle();
        check_eq("t1_busy_on", {31'd0, in_busy[2]}, 32'd1);
        check_eq("t1_no_stb_yet", {31'd0, out_stb}, 32'd0);
        in_req = '0;
        cycle();
        check_eq("t1_stb", {31'd0, out_stb}, 32'd1);
        check_eq("t1_sel", 32'(out_sel), 32'd2);
        check_eq("t1_data", 32'(out_data), 32'h1ABCDEF);
        check_eq("t1_busy_off", {31'd0, in_busy[2]}, 32'd0);
        repeat (2) cycle();

        // ch0, ch3, ch5 together from pointer 0
        apply_reset();
        base = sel_log.size();
        for (int i = 0; i < NCH; i++) set_word(i, 28'(32'h100 + i));
        in_req = 6'b101001;
        cycle();
        in_req = '0;
        repeat (4) cycle();
        check_eq("t2_count", 32'(sel_log.size() - base), 32'd3);
        if (sel_log.size() - base >= 3) begin
            check_eq("t2_first", sel_log[base], 32'd0);
            check_eq("t2_second", sel_log[base + 1], 32'd3);
            check_eq("t2_third", sel_log[base + 2], 32'd5);
        end
        // pointer back at 0: ch1 must beat ch5
        base   = sel_log.size();
        in_req = 6'b100010;
        cycle();
        in_req = '0;
        repeat (3) cycle();
        check_eq("t2_ptr_wrap", sel_log[base], 32'd1);

        // overwrite while stalled
        apply_reset();
        out_rdy = 1'b0;
        s0      = n_stb;
        in_req  = 6'b000010;
        set_word(1, 28'hA);
        cycle();
        set_word(1, 28'hB);
        cycle();
        in_req = '0;
        cycle();
        check_eq("t3_ovf", 32'(ovf), 32'h2);
        check_eq("t3_no_stb", 32'(n_stb - s0), 32'd0);
        base    = data_log.size();
        out_rdy = 1'b1;
        repeat (4) cycle();
`ifdef READBACK_SCHED_OVF_REPORT_EN
        check_eq("t3_count", 32'(data_log.size() - base), 32'd2);
        check_eq("t3_rep_sel", sel_log[base], 32'd7);
        check_eq("t3_rep_data", data_log[base], 32'hF000002);
        check_eq("t3_word", data_log[base + 1], 32'hB);
`else
        check_eq("t3_count", 32'(data_log.size() - base), 32'd1);
        check_eq("t3_word", data_log[base], 32'hB);
`endif
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        check_eq("t3_ovf_clr", 32'(ovf), 32'd0);
        // overflow coinciding with clear: set wins
        out_rdy = 1'b0;
        in_req  = 6'b000010;
        set_word(1, 28'hC);
        cycle();
        set_word(1, 28'hD);
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        in_req  = '0;
        check_eq("t3_set_wins", {31'd0, ovf[1]}, 32'd1);
        out_rdy = 1'b1;
        repeat (4) cycle();
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;

        // continuous requests on all channels, writer honours in_busy
        apply_reset();
        for (int i = 0; i < NCH; i++) tally[i] = 0;
        out_rdy = 1'b1;
        s0      = n_stb;
        cyc     = 0;
        while ((n_stb - s0) < 12 && cyc < 60) begin
            in_req = ~in_busy;
            for (int i = 0; i < NCH; i++) set_word(i, 28'((cyc << 4) | i));
            cycle();
            cyc++;
        end
        in_req = '0;
        check_eq("t4_strobes", 32'(n_stb - s0), 32'd12);
        for (int i = 0; i < NCH; i++) check_eq("t4_fair", 32'(tally[i]), 32'd2);
        check_eq("t4_no_ovf", 32'(ovf), 32'd0);
        repeat (8) cycle();

        // reset with slots 1 and 4 still full and a strobe in flight
        apply_reset();
        out_rdy = 1'b0;
        in_req  = 6'b010011;
        for (int i = 0; i < NCH; i++) set_word(i, 28'(32'h200 + i));
        cycle();
        in_req  = '0;
        out_rdy = 1'b1;
        cycle();
        check_eq("t5_inflight", {31'd0, out_stb}, 32'd1);
        check_eq("t5_busy_pre", 32'(in_busy), 32'h12);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t5_async_stb", {31'd0, out_stb}, 32'd0);
        check_eq("t5_async_busy", 32'(in_busy), 32'd0);
        check_eq("t5_async_data", 32'(out_data), 32'd0);
        check_eq("t5_async_sel", 32'(out_sel), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        s0  = n_stb;
        repeat (4) cycle();
        check_eq("t5_quiet", 32'(n_stb - s0), 32'd0);
        in_req = 6'b010000;
        set_word(4, 28'h4444444);
        cycle();
        in_req = '0;
        repeat (2) cycle();
        check_eq("t5_resume", 32'(n_stb - s0), 32'd1);

`ifdef READBACK_SCHED_OVF_REPORT_EN
        // overflow on ch4 produces a report before normal issue resumes
        apply_reset();
        out_rdy = 1'b0;
        in_req  = 6'b010000;
        set_word(4, 28'h0000041);
        cycle();
        set_word(4, 28'h0000042);
        cycle();
        in_req  = '0;
        base    = sel_log.size();
        out_rdy = 1'b1;
        repeat (4) cycle();
        check_eq("t6_rep_sel", sel_log[base], 32'd7);
        check_eq("t6_rep_data", data_log[base], 32'hF000010);
        check_eq("t6_next_sel", sel_log[base + 1], 32'd4);
        check_eq("t6_next_data", data_log[base + 1], 32'h42);
`else
        s0 = 0;
        foreach (sel_log[i]) if (sel_log[i] == 32'd7) s0++;
        check_eq("no_sel7", 32'(s0), 32'd0);
`endif
        check_eq("q_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
